// File: rtl/cpu_mode_loader.sv
// Front-panel mode sequencer and program loader: debounced keys step IDLE/IN/CHECK/RUN,
// load switch bytes into program RAM and step a read address for inspection.
module cpu_mode_loader #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode_key,
    input  logic              wr_key,
    input  logic              step_key,
    input  logic [7:0]        sw_data,
    output logic [1:0]        cpustate,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        ld_data,
    output logic              ld_we,
    output logic              chk_re,
    output logic              full,
    output logic              run_start
);
    localparam int unsigned        NKEY     = 3;
    localparam int unsigned        CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0]   DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [ADDR_W-1:0]  ADDR_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_IN    = 2'b01,
        S_CHECK = 2'b10,
        S_RUN   = 2'b11
    } state_e;

    logic [NKEY-1:0]   key_raw;
    logic [NKEY-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NKEY-1:0]   deb_q, deb_d, deb_prev_q, deb_prev_d;
    logic [CNT_W-1:0]  cnt_q [NKEY];
    logic [CNT_W-1:0]  cnt_d [NKEY];
    logic [NKEY-1:0]   press_c;
    logic              mode_press_c, wr_press_c, step_press_c;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        ld_data_q, ld_data_d;
    logic              ld_we_q, ld_we_d;
    logic              chk_re_q, chk_re_d;
    logic              full_q, full_d;
    logic              run_start_q, run_start_d;

    assign key_raw = {step_key, wr_key, mode_key};

    // Synchronize, then flip the debounced level after DEB_CYCLES consecutive differing samples.
    always_comb begin : key_path
        sync1_d    = key_raw;
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        for (int k = 0; k < NKEY; k++) begin
            cnt_d[k] = '0;
            if (sync2_q[k] != deb_q[k]) begin
                if (cnt_q[k] == DEB_LAST) begin
                    deb_d[k] = sync2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    assign press_c      = deb_q & ~deb_prev_q;
    assign mode_press_c = press_c[0];
    assign wr_press_c   = press_c[1];
    assign step_press_c = press_c[2];

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            deb_prev_q  <= '0;
            for (int k = 0; k < NKEY; k++) cnt_q[k] <= '0;
            state_q     <= S_IDLE;
            addr_q      <= '0;
            ld_data_q   <= '0;
            ld_we_q     <= 1'b0;
            chk_re_q    <= 1'b0;
            full_q      <= 1'b0;
            run_start_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_prev_d;
            for (int k = 0; k < NKEY; k++) cnt_q[k] <= cnt_d[k];
            state_q     <= state_d;
            addr_q      <= addr_d;
            ld_data_q   <= ld_data_d;
            ld_we_q     <= ld_we_d;
            chk_re_q    <= chk_re_d;
            full_q      <= full_d;
            run_start_q <= run_start_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        if (mode_press_c) begin
            state_d = state_e'(state_q + 2'd1);
        end
    end

    // Mode press wins over wr/step; a strobe already issued still finishes but its increment yields to mode entry.
    always_comb begin : outputs
        addr_d      = addr_q;
        ld_data_d   = ld_data_q;
        ld_we_d     = 1'b0;
        full_d      = full_q;
        chk_re_d    = (state_d == S_CHECK);
        run_start_d = (state_d == S_RUN) && (state_q != S_RUN);
        if (ld_we_q) begin
            if (addr_q == ADDR_MAX) begin
                full_d = 1'b1;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
        if (mode_press_c) begin
            case (state_d)
                S_IN: begin
                    addr_d = '0;
                    full_d = 1'b0;
                end
                S_CHECK: addr_d = '0;
                default: addr_d = addr_q;
            endcase
        end else if ((state_q == S_IN) && wr_press_c && !full_q) begin
            ld_we_d   = 1'b1;
            ld_data_d = sw_data;
        end else if ((state_q == S_CHECK) && step_press_c) begin
            addr_d = addr_q + ADDR_W'(1);
        end
    end

    assign cpustate  = state_q;
    assign addr      = addr_q;
    assign ld_data   = ld_data_q;
    assign ld_we     = ld_we_q;
    assign chk_re    = chk_re_q;
    assign full      = full_q;
    assign run_start = run_start_q;
endmodule

// File: tb/tb_cpu_mode_loader.sv
// Directed bench for cpu_mode_loader: table of key presses with expected results, plus
// hand sequences for press latency, glitch rejection, simultaneous keys and mid-IN reset.
module tb_cpu_mode_loader;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DEB    = 4;
    localparam int unsigned HOLD   = DEB + 6;
    localparam int K_MODE = 0;
    localparam int K_WR   = 1;
    localparam int K_STEP = 2;
    localparam int NV     = 19;

    logic              clk = 1'b0;
    logic              rst;
    logic              mode_key, wr_key, step_key;
    logic [7:0]        sw_data;
    logic [1:0]        cpustate;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        ld_data;
    logic              ld_we, chk_re, full, run_start;

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt   = 0;
    int rs_cnt   = 0;
    int chk_bad  = 0;
    int we_addr  = 0;
    int we_data  = 0;

    typedef struct {
        int         key;
        logic [7:0] d;
        int         st;
        int         a;
        int         f;
        int         we;
        int         wa;
        int         wd;
        int         rs;
    } vec_t;

    vec_t vec [NV];

    cpu_mode_loader #(.ADDR_W(ADDR_W), .DEB_CYCLES(DEB)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode_key  (mode_key),
        .wr_key    (wr_key),
        .step_key  (step_key),
        .sw_data   (sw_data),
        .cpustate  (cpustate),
        .addr      (addr),
        .ld_data   (ld_data),
        .ld_we     (ld_we),
        .chk_re    (chk_re),
        .full      (full),
        .run_start (run_start)
    );

    always #5 clk = ~clk;

    // Record write strobes, run_start pulses and any chk_re/cpustate disagreement.
    always @(negedge clk) begin
        if (ld_we === 1'b1) begin
            we_cnt  = we_cnt + 1;
            we_addr = int'(addr);
            we_data = int'(ld_data);
        end
        if (run_start === 1'b1) rs_cnt = rs_cnt + 1;
        if (chk_re !== (cpustate == 2'b10)) chk_bad = chk_bad + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic set_key(input int key, input logic v);
        case (key)
            K_MODE:  mode_key = v;
            K_WR:    wr_key   = v;
            default: step_key = v;
        endcase
    endtask

    task automatic press(input int key, input logic [7:0] d);
        @(negedge clk);
        we_cnt  = 0;
        rs_cnt  = 0;
        sw_data = d;
        set_key(key, 1'b1);
        repeat (HOLD) @(negedge clk);
        set_key(key, 1'b0);
        repeat (HOLD) @(negedge clk);
    endtask

    initial begin
        vec[0]  = '{K_MODE, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0};
        vec[1]  = '{K_WR,   8'hA5, 1, 1, 0, 1, 0, 8'hA5, 0};
        vec[2]  = '{K_WR,   8'h3C, 1, 2, 0, 1, 1, 8'h3C, 0};
        vec[3]  = '{K_WR,   8'h11, 1, 3, 0, 1, 2, 8'h11, 0};
        vec[4]  = '{K_WR,   8'h22, 1, 3, 1, 1, 3, 8'h22, 0};
        vec[5]  = '{K_WR,   8'h33, 1, 3, 1, 0, 0, 8'h00, 0};
        vec[6]  = '{K_MODE, 8'h00, 2, 0, 1, 0, 0, 8'h00, 0};
        vec[7]  = '{K_STEP, 8'h00, 2, 1, 1, 0, 0, 8'h00, 0};
        vec[8]  = '{K_STEP, 8'h00, 2, 2, 1, 0, 0, 8'h00, 0};
        vec[9]  = '{K_STEP, 8'h00, 2, 3, 1, 0, 0, 8'h00, 0};
        vec[10] = '{K_STEP, 8'h00, 2, 0, 1, 0, 0, 8'h00, 0};
        vec[11] = '{K_STEP, 8'h00, 2, 1, 1, 0, 0, 8'h00, 0};
        vec[12] = '{K_WR,   8'h44, 2, 1, 1, 0, 0, 8'h00, 0};
        vec[13] = '{K_MODE, 8'h00, 3, 1, 1, 0, 0, 8'h00, 1};
        vec[14] = '{K_STEP, 8'h00, 3, 1, 1, 0, 0, 8'h00, 0};
        vec[15] = '{K_WR,   8'h55, 3, 1, 1, 0, 0, 8'h00, 0};
        vec[16] = '{K_MODE, 8'h00, 0, 1, 1, 0, 0, 8'h00, 0};
        vec[17] = '{K_STEP, 8'h00, 0, 1, 1, 0, 0, 8'h00, 0};
        vec[18] = '{K_MODE, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0};

        rst = 1'b1; mode_key = 1'b0; wr_key = 1'b0; step_key = 1'b0; sw_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset cpustate", int'(cpustate), 0);
        chk("reset addr", int'(addr), 0);
        chk("reset ld_we", int'(ld_we), 0);
        chk("reset chk_re", int'(chk_re), 0);
        chk("reset full", int'(full), 0);
        chk("reset run_start", int'(run_start), 0);

        for (int i = 0; i < NV; i++) begin
            press(vec[i].key, vec[i].d);
            chk($sformatf("v%0d cpustate", i), int'(cpustate), vec[i].st);
            chk($sformatf("v%0d addr", i), int'(addr), vec[i].a);
            chk($sformatf("v%0d full", i), int'(full), vec[i].f);
            chk($sformatf("v%0d ld_we pulses", i), we_cnt, vec[i].we);
            chk($sformatf("v%0d run_start pulses", i), rs_cnt, vec[i].rs);
            if (vec[i].we == 1) begin
                chk($sformatf("v%0d write addr", i), we_addr, vec[i].wa);
                chk($sformatf("v%0d write data", i), we_data, vec[i].wd);
            end
        end

        // Press latency in IN at addr 0: strobe after edge N+2+DEB, increment one edge later.
        @(negedge clk);
        wr_key = 1'b1; sw_data = 8'h5A;
        @(posedge clk);
        repeat (DEB + 1) @(posedge clk);
        @(negedge clk);
        chk("latency no early strobe", int'(ld_we), 0);
        @(negedge clk);
        chk("latency strobe", int'(ld_we), 1);
        chk("latency strobe data", int'(ld_data), 8'h5A);
        chk("latency strobe addr held", int'(addr), 0);
        @(negedge clk);
        chk("latency strobe ends", int'(ld_we), 0);
        chk("latency addr inc", int'(addr), 1);
        wr_key = 1'b0;
        repeat (HOLD) @(negedge clk);

        // Glitch one sample short of the debounce threshold.
        we_cnt = 0;
        wr_key = 1'b1;
        repeat (DEB - 1) @(negedge clk);
        wr_key = 1'b0;
        repeat (3 * HOLD) @(negedge clk);
        chk("glitch no write", we_cnt, 0);
        chk("glitch addr", int'(addr), 1);

        // Mode and wr in the same cycle: mode change only.
        @(negedge clk);
        we_cnt = 0;
        mode_key = 1'b1; wr_key = 1'b1; sw_data = 8'hEE;
        repeat (HOLD) @(negedge clk);
        mode_key = 1'b0; wr_key = 1'b0;
        repeat (HOLD) @(negedge clk);
        chk("simul cpustate", int'(cpustate), 2);
        chk("simul no write", we_cnt, 0);
        chk("simul addr", int'(addr), 0);

        // Back to IN, then reset while a wr press is about to act.
        press(K_MODE, 8'h00);
        press(K_MODE, 8'h00);
        press(K_MODE, 8'h00);
        chk("pre-reset cpustate", int'(cpustate), 1);
        @(negedge clk);
        we_cnt = 0;
        wr_key = 1'b1; sw_data = 8'h77;
        @(posedge clk);
        repeat (DEB + 1) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; wr_key = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mid reset cpustate", int'(cpustate), 0);
        chk("mid reset ld_data", int'(ld_data), 0);
        chk("mid reset ld_we", int'(ld_we), 0);
        chk("mid reset chk_re", int'(chk_re), 0);
        chk("mid reset run_start", int'(run_start), 0);
        repeat (3 * HOLD) @(negedge clk);
        chk("mid reset no write", we_cnt, 0);
        chk("mid reset stays idle", int'(cpustate), 0);
        chk("chk_re tracks CHECK", chk_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
